store_forward_buffer: RTL and testbench
=======================================

Name: store_forward_buffer

Overview:
- ROB-side store queue. It is the responder to the load/store unit's store and forwarding interfaces.
- Accepts executed stores in program order and holds them until the ROB commits them.
- Drains committed stores to the data cache write port.
- Answers same-cycle load forwarding queries with data, a hit, or a stall.

Parameters:
- DATA_WIDTH, 32, data word bits (byte lanes = DATA_WIDTH/8)
- ADDR_BITS, 32, address bits
- MICROOP, 5, microoperation bits
- ROB_TICKET, 3, ROB ticket bits
- DEPTH, 8, entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- store_valid  in  1  store arriving from LSU
- store_address  in  ADDR_BITS  store byte address
- store_data  in  DATA_WIDTH  raw rs2 value, unshifted
- store_microop  in  MICROOP  SB/SH/SW
- store_ticket  in  ROB_TICKET  ROB ticket
- store_ready  out  1  not full
- commit_valid  in  1  ROB commits the oldest uncommitted store
- commit_ticket  in  ROB_TICKET  ticket of that store
- flush  in  1  squash all uncommitted entries
- frw_address  in  ADDR_BITS  load query address
- frw_microop  in  MICROOP  load query microop
- frw_data  out  DATA_WIDTH  forwarded data, right-aligned to bit 0
- frw_valid  out  1  full forward hit
- frw_stall  out  1  conflict; load must retry
- cache_writeback_valid  out  1  committed head store presented to cache
- cache_wb_ready  in  1  cache accepts the write
- cache_wb_address  out  ADDR_BITS  address of head store
- cache_wb_data  out  DATA_WIDTH  lane-aligned head store data
- cache_wb_mask  out  DATA_WIDTH/8  byte enables
- cache_wb_microop  out  MICROOP  microop of head store

Behaviour:
- Storage:
  - Circular FIFO with head, commit and tail pointers, each with an extra wrap bit.
  - Entry fields: addr, lane-aligned data word, byte mask, microop, ticket, committed.
- Allocation, on store_valid & store_ready:
  - data stored as store_data << 8*addr[1:0];
  - mask: SB=0001, SH=0011, SW=1111, each << addr[1:0];
  - tail advances next edge.
- store_valid while full: store is dropped. Assertion fires.
- Commit, on commit_valid:
  - marks the entry at the commit pointer and advances it.
  - commit_ticket must equal that entry's ticket; otherwise assertion.
  - commit_valid with no uncommitted entries: ignored, plus assertion.
  - An entry allocated in the same cycle is not committable that cycle.
- Drain:
  - cache_writeback_valid = head entry valid & committed (combinational from registers).
  - Head pops on cache_writeback_valid & cache_wb_ready.
- Flush: tail := commit pointer next edge; committed entries survive.
- Simultaneous events:
  - alloc + commit + drain in one cycle is legal.
  - flush wins over alloc; the flushed-cycle store is discarded.
  - drain proceeds during flush.
- Forwarding (combinational, zero latency):
  - Load byte mask comes from LB/LBU=1, LH/LHU=2, LW=4 bytes at offset addr[1:0].
  - Misaligned load (half at offset 3, word at offset ≠0): frw_stall=1 if any entry is valid.
  - Otherwise, scan from tail-1 back to head (committed entries included). Pick the youngest entry with equal addr[ADDR_BITS-1:2] and a nonzero mask intersection.
    - No match: frw_valid=0, frw_stall=0.
    - Entry mask covers the load mask: frw_valid=1, frw_data = entry_data >> 8*load_addr[1:0].
    - Partial cover: frw_stall=1, frw_valid=0.
  - frw_data = 0 when frw_valid=0.
  - Same-cycle arriving store is not visible to lookup.
- Reset (asynchronous, any time):
  - all pointers 0, all entries invalid;
  - store_ready=1, cache_writeback_valid=0, frw_valid=0, frw_stall=0, frw_data=0, cache_wb_* = 0.
- Full iff tail - head == DEPTH, counting committed entries.
- Pointer wrap via the extra bit; DEPTH-1 → 0 wraps cleanly.

Decomposition:
- Shared package holds:
  - microop constants: LW=00001, LH=00010, LB=00011, LHU=00100, LBU=00101, SW=00110, SH=00111, SB=01000;
  - typedef sfb_entry_t;
  - functions for the byte-mask and lane-shift computation.
- One natural sub-module: sfb_match_select, the youngest-match priority scan over the entry array, combinational.

Test Plan:
- SW 0x100=0xDEADBEEF, then query LW 0x100 → frw_valid=1, frw_data=0xDEADBEEF, frw_stall=0.
- SB 0x103=0xAB, then query LBU 0x103 → frw_valid=1, data 0x000000AB; query LW 0x100 → frw_stall=1.
- SW 0x200=1 then SW 0x200=2, query LW 0x200 → data 2 (youngest). Commit both, cache_wb_ready=1 → writebacks 1 then 2, mask 1111, on consecutive cycles.
- Fill 8 stores → store_ready=0. Commit 3, flush → 5 entries squashed. The 3 drain in order, then store_ready=1 and the buffer is empty.
- Hold cache_wb_ready=0 with committed head → cache_writeback_valid stays 1 and the entry is held. Assert rst mid-stream → all outputs 0 immediately, store_ready=1.
- Query LH 0x303 with any entry valid → frw_stall=1. With the buffer empty → frw_stall=0, frw_valid=0.

Source files
------------

// File: rtl/store_forward_buffer_pkg.sv
// Shared definitions for the store-forward buffer.
// Holds the microop encodings, the stored-entry record and the helpers that
// turn a microop plus a byte offset into byte-lane masks and lane shifts.
// The default widths here are the widths the buffer is built with; the
// entry record uses them directly.
package store_forward_buffer_pkg;

  localparam int SFB_DATA_W = 32;
  localparam int SFB_ADDR_W = 32;
  localparam int SFB_MOP_W  = 5;
  localparam int SFB_TKT_W  = 3;
  localparam int SFB_LANES  = SFB_DATA_W / 8;

  localparam logic [SFB_MOP_W-1:0] MOP_LW  = 5'b00001;
  localparam logic [SFB_MOP_W-1:0] MOP_LH  = 5'b00010;
  localparam logic [SFB_MOP_W-1:0] MOP_LB  = 5'b00011;
  localparam logic [SFB_MOP_W-1:0] MOP_LHU = 5'b00100;
  localparam logic [SFB_MOP_W-1:0] MOP_LBU = 5'b00101;
  localparam logic [SFB_MOP_W-1:0] MOP_SW  = 5'b00110;
  localparam logic [SFB_MOP_W-1:0] MOP_SH  = 5'b00111;
  localparam logic [SFB_MOP_W-1:0] MOP_SB  = 5'b01000;

  // One buffered store; data is already shifted into its byte lanes.
  typedef struct packed {
    logic [SFB_ADDR_W-1:0] addr;
    logic [SFB_DATA_W-1:0] data;
    logic [SFB_LANES-1:0]  mask;
    logic [SFB_MOP_W-1:0]  microop;
    logic [SFB_TKT_W-1:0]  ticket;
    logic                  committed;
  } sfb_entry_t;

  // Lanes a store writes. Lanes pushed past the top of the word are dropped.
  function automatic logic [SFB_LANES-1:0] store_byte_mask(input logic [SFB_MOP_W-1:0] mop,
                                                           input logic [1:0]           offset);
    logic [SFB_LANES-1:0] base;
    case (mop)
      MOP_SB:  base = 4'b0001;
      MOP_SH:  base = 4'b0011;
      MOP_SW:  base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << offset;
  endfunction

  // Lanes a load reads; non-load microops read nothing and so never match.
  function automatic logic [SFB_LANES-1:0] load_byte_mask(input logic [SFB_MOP_W-1:0] mop,
                                                          input logic [1:0]           offset);
    logic [SFB_LANES-1:0] base;
    case (mop)
      MOP_LB, MOP_LBU: base = 4'b0001;
      MOP_LH, MOP_LHU: base = 4'b0011;
      MOP_LW:          base = 4'b1111;
      default:         base = 4'b0000;
    endcase
    return base << offset;
  endfunction

  // A load that would straddle the word boundary cannot be forwarded.
  function automatic logic load_is_misaligned(input logic [SFB_MOP_W-1:0] mop,
                                              input logic [1:0]           offset);
    return (((mop == MOP_LH) || (mop == MOP_LHU)) && (offset == 2'd3)) ||
           ((mop == MOP_LW) && (offset != 2'd0));
  endfunction

  function automatic logic [SFB_DATA_W-1:0] lane_align(input logic [SFB_DATA_W-1:0] data,
                                                       input logic [1:0]            offset);
    return data << {offset, 3'b000};
  endfunction

  function automatic logic [SFB_DATA_W-1:0] lane_extract(input logic [SFB_DATA_W-1:0] data,
                                                         input logic [1:0]            offset);
    return data >> {offset, 3'b000};
  endfunction

endpackage

// File: rtl/store_forward_buffer_match_select.sv
// Youngest-match priority scan for the store-forward buffer.
//   hit_i      : per physical slot, slot is live and overlaps the load
//   tail_idx_i : physical slot the next store will be written to
//   found_o    : at least one slot hit
//   index_o    : slot of the youngest hit (closest behind the tail)
module sfb_match_select
  import store_forward_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] hit_i,
  input  logic [PW-1:0]    tail_idx_i,
  output logic             found_o,
  output logic [PW-1:0]    index_o
);

  logic [PW-1:0] probe;

  // Walk backwards from tail-1; the first hit seen is the youngest store.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    probe   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      probe = tail_idx_i - PW'(k);
      if (!found_o && hit_i[probe]) begin
        found_o = 1'b1;
        index_o = probe;
      end
    end
  end

endmodule

// File: rtl/store_forward_buffer.sv
// ROB-side store queue with load forwarding.
// Stores arrive in program order, wait for ROB commit, then drain to the
// data cache. Loads query the buffer combinationally for forwarded data.
//   store_*       : executed store from the LSU, accepted when store_ready
//   commit_*      : ROB commits the oldest uncommitted store
//   flush         : squash every uncommitted entry
//   frw_*         : load forwarding query and its answer (data/hit/stall)
//   cache_wb_*    : committed head store offered to the cache write port
module store_forward_buffer
  import store_forward_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = SFB_DATA_W,
  parameter int ADDR_BITS  = SFB_ADDR_W,
  parameter int MICROOP    = SFB_MOP_W,
  parameter int ROB_TICKET = SFB_TKT_W,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    store_valid,
  input  logic [ADDR_BITS-1:0]    store_address,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [MICROOP-1:0]      store_microop,
  input  logic [ROB_TICKET-1:0]   store_ticket,
  output logic                    store_ready,
  input  logic                    commit_valid,
  input  logic [ROB_TICKET-1:0]   commit_ticket,
  input  logic                    flush,
  input  logic [ADDR_BITS-1:0]    frw_address,
  input  logic [MICROOP-1:0]      frw_microop,
  output logic [DATA_WIDTH-1:0]   frw_data,
  output logic                    frw_valid,
  output logic                    frw_stall,
  output logic                    cache_writeback_valid,
  input  logic                    cache_wb_ready,
  output logic [ADDR_BITS-1:0]    cache_wb_address,
  output logic [DATA_WIDTH-1:0]   cache_wb_data,
  output logic [DATA_WIDTH/8-1:0] cache_wb_mask,
  output logic [MICROOP-1:0]      cache_wb_microop
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] PTR_ONE    = (PW+1)'(1);

  sfb_entry_t entries_q [DEPTH];
  sfb_entry_t entries_d [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]   head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [PW-1:0] head_idx, commit_idx, tail_idx;
  logic [PW:0]   count;
  logic          full, has_uncommitted, alloc, do_commit, drain;

  logic [SFB_LANES-1:0] load_mask;
  logic                 load_misaligned;
  logic [DEPTH-1:0]     entry_hit;
  logic                 match_found;
  logic [PW-1:0]        match_idx;

  assign head_idx   = head_q[PW-1:0];
  assign commit_idx = commit_q[PW-1:0];
  assign tail_idx   = tail_q[PW-1:0];

  assign count           = tail_q - head_q;
  assign full            = (count == FULL_COUNT);
  assign store_ready     = ~full;
  assign has_uncommitted = (commit_q != tail_q);
  assign alloc           = store_valid & ~full & ~flush;
  assign do_commit       = commit_valid & has_uncommitted;

  assign cache_writeback_valid = (count != '0) & entries_q[head_idx].committed;
  assign drain                 = cache_writeback_valid & cache_wb_ready;

  assign cache_wb_address = cache_writeback_valid ? entries_q[head_idx].addr    : '0;
  assign cache_wb_data    = cache_writeback_valid ? entries_q[head_idx].data    : '0;
  assign cache_wb_mask    = cache_writeback_valid ? entries_q[head_idx].mask    : '0;
  assign cache_wb_microop = cache_writeback_valid ? entries_q[head_idx].microop : '0;

  // Next-state: allocate at tail, commit at the commit pointer, pop the head.
  // A flush pulls the tail back to the (possibly just advanced) commit pointer,
  // which also discards any store arriving in the same cycle.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    commit_d  = commit_q;
    tail_d    = tail_q;
    if (alloc) begin
      entries_d[tail_idx].addr      = store_address;
      entries_d[tail_idx].data      = lane_align(store_data, store_address[1:0]);
      entries_d[tail_idx].mask      = store_byte_mask(store_microop, store_address[1:0]);
      entries_d[tail_idx].microop   = store_microop;
      entries_d[tail_idx].ticket    = store_ticket;
      entries_d[tail_idx].committed = 1'b0;
      tail_d = tail_q + PTR_ONE;
    end
    if (do_commit) begin
      entries_d[commit_idx].committed = 1'b1;
      commit_d = commit_q + PTR_ONE;
    end
    if (drain) begin
      head_d = head_q + PTR_ONE;
    end
    if (flush) begin
      tail_d = commit_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  assign load_mask       = load_byte_mask(frw_microop, frw_address[1:0]);
  assign load_misaligned = load_is_misaligned(frw_microop, frw_address[1:0]);

  // A slot is live when its distance from the head is below the occupancy;
  // it hits when it is live, in the same word and shares at least one lane.
  always_comb begin
    entry_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_hit[i] = ({1'b0, PW'(i) - head_idx} < count) &&
                     (entries_q[i].addr[ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2]) &&
                     (|(entries_q[i].mask & load_mask));
    end
  end

  sfb_match_select #(.DEPTH(DEPTH), .PW(PW)) u_match_select (
    .hit_i      (entry_hit),
    .tail_idx_i (tail_idx),
    .found_o    (match_found),
    .index_o    (match_idx)
  );

  // Only the youngest overlapping store matters: if it covers every lane the
  // load reads we forward it, otherwise older data would be mixed in, so stall.
  always_comb begin
    frw_valid = 1'b0;
    frw_stall = 1'b0;
    frw_data  = '0;
    if (load_misaligned) begin
      frw_stall = (count != '0);
    end else if (match_found) begin
      if ((entries_q[match_idx].mask & load_mask) == load_mask) begin
        frw_valid = 1'b1;
        frw_data  = lane_extract(entries_q[match_idx].data, frw_address[1:0]);
      end else begin
        frw_stall = 1'b1;
      end
    end
  end

  // Protocol misuse by the LSU or ROB.
  a_no_store_when_full: assert property (@(posedge clk) disable iff (rst)
    store_valid |-> store_ready);
  a_commit_has_target: assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> has_uncommitted);
  a_commit_ticket_match: assert property (@(posedge clk) disable iff (rst)
    do_commit |-> (commit_ticket == entries_q[commit_idx].ticket));

endmodule

// File: tb/tb_store_forward_buffer.sv
// Self-checking bench for store_forward_buffer: a queue-based reference model
// compared against the DUT every cycle, plus directed literal expectations.
module tb_store_forward_buffer;

  localparam int DEPTH = 8;

  localparam logic [4:0] LW  = 5'b00001;
  localparam logic [4:0] LH  = 5'b00010;
  localparam logic [4:0] LB  = 5'b00011;
  localparam logic [4:0] LHU = 5'b00100;
  localparam logic [4:0] LBU = 5'b00101;
  localparam logic [4:0] SW  = 5'b00110;
  localparam logic [4:0] SH  = 5'b00111;
  localparam logic [4:0] SB  = 5'b01000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        store_valid;
  logic [31:0] store_address;
  logic [31:0] store_data;
  logic [4:0]  store_microop;
  logic [2:0]  store_ticket;
  logic        store_ready;
  logic        commit_valid;
  logic [2:0]  commit_ticket;
  logic        flush;
  logic [31:0] frw_address;
  logic [4:0]  frw_microop;
  logic [31:0] frw_data;
  logic        frw_valid;
  logic        frw_stall;
  logic        cache_writeback_valid;
  logic        cache_wb_ready;
  logic [31:0] cache_wb_address;
  logic [31:0] cache_wb_data;
  logic [3:0]  cache_wb_mask;
  logic [4:0]  cache_wb_microop;

  int checks = 0;
  int errors = 0;

  store_forward_buffer dut (
    .clk                   (clk),
    .rst                   (rst),
    .store_valid           (store_valid),
    .store_address         (store_address),
    .store_data            (store_data),
    .store_microop         (store_microop),
    .store_ticket          (store_ticket),
    .store_ready           (store_ready),
    .commit_valid          (commit_valid),
    .commit_ticket         (commit_ticket),
    .flush                 (flush),
    .frw_address           (frw_address),
    .frw_microop           (frw_microop),
    .frw_data              (frw_data),
    .frw_valid             (frw_valid),
    .frw_stall             (frw_stall),
    .cache_writeback_valid (cache_writeback_valid),
    .cache_wb_ready        (cache_wb_ready),
    .cache_wb_address      (cache_wb_address),
    .cache_wb_data         (cache_wb_data),
    .cache_wb_mask         (cache_wb_mask),
    .cache_wb_microop      (cache_wb_microop)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of raw stores; the first ncom of
  // them are committed.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] raw;
    logic [4:0]  mop;
  } model_store_t;

  model_store_t mq[$];
  int ncom = 0;

  function automatic int storeBytes(input logic [4:0] mop);
    case (mop)
      SB:      return 1;
      SH:      return 2;
      SW:      return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int loadBytes(input logic [4:0] mop);
    case (mop)
      LB, LBU: return 1;
      LH, LHU: return 2;
      LW:      return 4;
      default: return 0;
    endcase
  endfunction

  // Byte lanes of the addressed word touched by an access of nbytes.
  function automatic logic [3:0] lanesTouched(input logic [31:0] addr, input int nbytes);
    logic [3:0] m;
    int off;
    m = 4'b0000;
    off = int'(addr[1:0]);
    for (int b = 0; b < nbytes; b++) begin
      if (off + b < 4) m[off + b] = 1'b1;
    end
    return m;
  endfunction

  // The store's value as it sits in the memory word.
  function automatic logic [31:0] wordImage(input logic [31:0] raw, input logic [31:0] addr);
    logic [63:0] w;
    w = {32'd0, raw} * (64'd1 << (8 * int'(addr[1:0])));
    return w[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Compare every DUT output against what the model says it must be now.
  task automatic compareModel();
    logic        eCwv, eValid, eStall;
    logic [31:0] eAddr, eWbData, eData;
    logic [3:0]  eMask, lmask, smask;
    logic [4:0]  eMop;
    int          lb, loff;
    eCwv    = (ncom > 0);
    eAddr   = eCwv ? mq[0].addr : 32'd0;
    eWbData = eCwv ? wordImage(mq[0].raw, mq[0].addr) : 32'd0;
    eMask   = eCwv ? lanesTouched(mq[0].addr, storeBytes(mq[0].mop)) : 4'd0;
    eMop    = eCwv ? mq[0].mop : 5'd0;
    eValid  = 1'b0;
    eStall  = 1'b0;
    eData   = 32'd0;
    lb      = loadBytes(frw_microop);
    loff    = int'(frw_address[1:0]);
    if (lb > 1 && loff + lb > 4) begin
      eStall = (mq.size() > 0);
    end else if (lb > 0) begin
      lmask = lanesTouched(frw_address, lb);
      for (int i = mq.size() - 1; i >= 0; i--) begin
        smask = lanesTouched(mq[i].addr, storeBytes(mq[i].mop));
        if (mq[i].addr[31:2] == frw_address[31:2] && (smask & lmask) != 4'd0) begin
          if ((smask & lmask) == lmask) begin
            eValid = 1'b1;
            eData  = wordImage(mq[i].raw, mq[i].addr) >> (8 * loff);
          end else begin
            eStall = 1'b1;
          end
          break;
        end
      end
    end
    checkOutput("model store_ready", store_ready, (mq.size() < DEPTH));
    checkOutput("model wb_valid", cache_writeback_valid, eCwv);
    checkOutput("model wb_address", cache_wb_address, eAddr);
    checkOutput("model wb_data", cache_wb_data, eWbData);
    checkOutput("model wb_mask", cache_wb_mask, eMask);
    checkOutput("model wb_microop", cache_wb_microop, eMop);
    checkOutput("model frw_valid", frw_valid, eValid);
    checkOutput("model frw_stall", frw_stall, eStall);
    checkOutput("model frw_data", frw_data, eData);
  endtask

  always @(negedge clk) compareModel();

  // Model state update with the inputs seen at the clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      ncom <= 0;
    end else begin
      int  nc;
      bit  doDrain, doCommit, doAlloc;
      nc       = ncom;
      doDrain  = (ncom > 0) && cache_wb_ready;
      doCommit = commit_valid && (ncom < mq.size());
      doAlloc  = store_valid && (mq.size() < DEPTH) && !flush;
      if (doCommit) nc++;
      if (flush) begin
        while (mq.size() > nc) void'(mq.pop_back());
      end else if (doAlloc) begin
        mq.push_back('{store_address, store_data, store_microop});
      end
      if (doDrain) begin
        void'(mq.pop_front());
        nc--;
      end
      ncom <= nc;
    end
  end

  // Advance n clock edges, then drop the single-cycle request pulses.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
    store_valid  = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic setStore(input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] mop, input logic [2:0] tkt);
    store_valid   = 1'b1;
    store_address = addr;
    store_data    = data;
    store_microop = mop;
    store_ticket  = tkt;
  endtask

  task automatic pushStore(input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] mop, input logic [2:0] tkt);
    setStore(addr, data, mop, tkt);
    applyStimulus(1);
  endtask

  task automatic commitStore(input logic [2:0] tkt);
    commit_valid  = 1'b1;
    commit_ticket = tkt;
    applyStimulus(1);
  endtask

  task automatic query(input logic [31:0] addr, input logic [4:0] mop);
    frw_address = addr;
    frw_microop = mop;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    store_valid    = 1'b0;
    store_address  = '0;
    store_data     = '0;
    store_microop  = '0;
    store_ticket   = '0;
    commit_valid   = 1'b0;
    commit_ticket  = '0;
    flush          = 1'b0;
    frw_address    = '0;
    frw_microop    = LW;
    cache_wb_ready = 1'b0;
    rst            = 1'b1;
    applyStimulus(2);
    checkOutput("reset store_ready", store_ready, 1);
    checkOutput("reset wb_valid", cache_writeback_valid, 0);
    checkOutput("reset frw_valid", frw_valid, 0);
    checkOutput("reset frw_stall", frw_stall, 0);
    checkOutput("reset wb_address", cache_wb_address, 0);
    rst = 1'b0;

    // Word store forwarded to a word load.
    pushStore(32'h100, 32'hDEADBEEF, SW, 3'd0);
    query(32'h100, LW);
    checkOutput("sw fwd valid", frw_valid, 1);
    checkOutput("sw fwd data", frw_data, 32'hDEADBEEF);
    checkOutput("sw fwd stall", frw_stall, 0);

    // Younger byte store: exact byte forwards, covering word load stalls.
    pushStore(32'h103, 32'h000000AB, SB, 3'd1);
    query(32'h103, LBU);
    checkOutput("sb fwd valid", frw_valid, 1);
    checkOutput("sb fwd data", frw_data, 32'h000000AB);
    query(32'h100, LW);
    checkOutput("partial stall", frw_stall, 1);
    checkOutput("partial valid", frw_valid, 0);

    cache_wb_ready = 1'b1;
    commitStore(3'd0);
    checkOutput("wb0 valid", cache_writeback_valid, 1);
    checkOutput("wb0 address", cache_wb_address, 32'h100);
    checkOutput("wb0 data", cache_wb_data, 32'hDEADBEEF);
    checkOutput("wb0 mask", cache_wb_mask, 4'b1111);
    commitStore(3'd1);
    checkOutput("wb1 address", cache_wb_address, 32'h103);
    checkOutput("wb1 data", cache_wb_data, 32'hAB000000);
    checkOutput("wb1 mask", cache_wb_mask, 4'b1000);
    applyStimulus(1);
    checkOutput("drained wb_valid", cache_writeback_valid, 0);

    // Two stores to one word: youngest forwards; held then drained in order.
    cache_wb_ready = 1'b0;
    pushStore(32'h200, 32'd1, SW, 3'd2);
    pushStore(32'h200, 32'd2, SW, 3'd3);
    query(32'h200, LW);
    checkOutput("youngest data", frw_data, 32'd2);
    commitStore(3'd2);
    commitStore(3'd3);
    applyStimulus(3);
    checkOutput("held wb_valid", cache_writeback_valid, 1);
    checkOutput("held wb_data", cache_wb_data, 32'd1);
    cache_wb_ready = 1'b1;
    #1;
    checkOutput("wb first data", cache_wb_data, 32'd1);
    applyStimulus(1);
    checkOutput("wb second data", cache_wb_data, 32'd2);
    checkOutput("wb second mask", cache_wb_mask, 4'b1111);
    applyStimulus(1);
    checkOutput("pair drained", cache_writeback_valid, 0);

    // Fill to full, commit three, flush the other five, drain the three.
    cache_wb_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pushStore(32'h400 + 32'(4 * k), 32'h10 + 32'(k), SW, 3'((4 + k) % 8));
    end
    checkOutput("full store_ready", store_ready, 0);
    commitStore(3'd4);
    commitStore(3'd5);
    commitStore(3'd6);
    flush = 1'b1;
    applyStimulus(1);
    checkOutput("post-flush ready", store_ready, 1);
    cache_wb_ready = 1'b1;
    #1;
    checkOutput("flush drain 0", cache_wb_address, 32'h400);
    applyStimulus(1);
    checkOutput("flush drain 1", cache_wb_address, 32'h404);
    applyStimulus(1);
    checkOutput("flush drain 2", cache_wb_address, 32'h408);
    applyStimulus(1);
    checkOutput("flush empty wb", cache_writeback_valid, 0);
    checkOutput("flush empty ready", store_ready, 1);
    query(32'h40C, LW);
    checkOutput("squashed not visible", frw_valid, 0);

    // A store arriving with flush is discarded.
    setStore(32'h500, 32'h55, SW, 3'd7);
    flush = 1'b1;
    applyStimulus(1);
    query(32'h500, LW);
    checkOutput("flush beats alloc", frw_valid, 0);
    checkOutput("flush beats alloc wb", cache_writeback_valid, 0);

    // Allocation, commit and drain in the same cycle.
    pushStore(32'h800, 32'h11, SW, 3'd7);
    setStore(32'h804, 32'h22, SW, 3'd0);
    commitStore(3'd7);
    setStore(32'h808, 32'h33, SH, 3'd1);
    commitStore(3'd0);
    checkOutput("overlap head", cache_wb_address, 32'h804);
    commitStore(3'd1);
    checkOutput("overlap half mask", cache_wb_mask, 4'b0011);
    applyStimulus(1);
    checkOutput("overlap drained", cache_writeback_valid, 0);

    // Misaligned half with a live entry stalls.
    cache_wb_ready = 1'b0;
    pushStore(32'h700, 32'h77, SW, 3'd2);
    query(32'h303, LH);
    checkOutput("misaligned stall", frw_stall, 1);
    checkOutput("misaligned valid", frw_valid, 0);

    // Reset asserted mid-cycle with a committed head waiting.
    commitStore(3'd2);
    checkOutput("pre-reset wb_valid", cache_writeback_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst wb_valid", cache_writeback_valid, 0);
    checkOutput("async rst wb_address", cache_wb_address, 0);
    checkOutput("async rst wb_data", cache_wb_data, 0);
    checkOutput("async rst ready", store_ready, 1);
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(1);
    query(32'h303, LH);
    checkOutput("empty misaligned stall", frw_stall, 0);
    checkOutput("empty misaligned valid", frw_valid, 0);

    applyStimulus(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
